// File: rtl/mips_pkg.sv
// Shared types and constants for the PC sequencing path.
// State encoding, address type and the reset/halt addresses.
package mips_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    SEQ,
    DELAY,
    HALTED
  } state_t;

  localparam addr_t RESET_VECTOR_C = 32'hBFC00000;
  localparam addr_t HALT_ADDR_C    = 32'h00000000;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target computation and priority selection.
// Register jump beats absolute jump beats conditional branch.
module pc_target_calc
  import mips_pkg::*;
(
  input  addr_t       pc4_i,
  input  logic        condition_met_i,
  input  logic [31:0] branch_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jump_reg_i,
  input  logic [31:0] reg_target_i,
  output addr_t       target_o,
  output logic        redirect_o
);

  addr_t br_tgt;
  addr_t jmp_tgt;

  assign br_tgt  = pc4_i + (branch_offset_i << 2);
  assign jmp_tgt = {pc4_i[31:28], jump_index_i, 2'b00};

  always_comb begin
    target_o   = '0;
    redirect_o = 1'b0;
    if (jump_reg_i) begin
      target_o   = reg_target_i;
      redirect_o = 1'b1;
    end else if (jump_i) begin
      target_o   = jmp_tgt;
      redirect_o = 1'b1;
    end else if (condition_met_i) begin
      target_o   = br_tgt;
      redirect_o = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner with one-instruction branch delay slot
// and halt detection on a redirect into HALT_ADDR.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter addr_t RESET_VECTOR = RESET_VECTOR_C,
  parameter addr_t HALT_ADDR    = HALT_ADDR_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        condition_met,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        in_delay_slot,
  output logic        active
);

  state_t state_q;
  addr_t  pc_q;
  addr_t  pend_q;
  addr_t  pc4;
  addr_t  tgt;
  logic   redir;

  assign pc4 = pc_q + 32'd4;

  pc_target_calc u_calc (
    .pc4_i           (pc4),
    .condition_met_i (condition_met),
    .branch_offset_i (branch_offset),
    .jump_i          (jump),
    .jump_index_i    (jump_index),
    .jump_reg_i      (jump_reg),
    .reg_target_i    (reg_target),
    .target_o        (tgt),
    .redirect_o      (redir)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
    end else if (advance) begin
      unique case (state_q)
        SEQ: begin
          pc_q <= pc4;
          if (redir) begin
            pend_q  <= tgt;
            state_q <= DELAY;
          end
        end
        DELAY: begin
          // Delay slot retired: the held target now takes effect.
          pc_q    <= pend_q;
          state_q <= (pend_q == HALT_ADDR) ? HALTED : SEQ;
        end
        HALTED: ;
        default: state_q <= SEQ;
      endcase
    end
  end

  assign pc            = pc_q;
  assign link_addr     = pc_q + 32'd8;
  assign in_delay_slot = (state_q == DELAY);
  assign active        = (state_q != HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        advance;
  logic        condition_met;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        in_delay_slot;
  logic        active;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] RV = 32'hBFC00000;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .advance       (advance),
    .condition_met (condition_met),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .pc            (pc),
    .link_addr     (link_addr),
    .in_delay_slot (in_delay_slot),
    .active        (active)
  );

  always #5 clk = ~clk;

  // Reference model: a pending-redirect queue holding at most one target.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_halt;

  task automatic model_step();
    logic [31:0] p4;
    if (reset) begin
      m_pc = RV;
      m_q.delete();
      m_halt = 1'b0;
    end else if (advance && !m_halt) begin
      if (m_q.size() != 0) begin
        m_pc = m_q.pop_front();
        if (m_pc == 32'h0) m_halt = 1'b1;
      end else begin
        p4 = m_pc + 4;
        if (jump_reg)
          m_q.push_back(reg_target);
        else if (jump)
          m_q.push_back({p4[31:28], jump_index, 2'b00});
        else if (condition_met)
          m_q.push_back(p4 + branch_offset * 4);
        m_pc = p4;
      end
    end
  endtask

  task automatic cyc(input logic rs, input logic adv,
                     input logic cm, input logic [31:0] off,
                     input logic j, input logic [25:0] ji,
                     input logic jr, input logic [31:0] rt);
    reset = rs; advance = adv; condition_met = cm;
    branch_offset = off; jump = j; jump_index = ji;
    jump_reg = jr; reg_target = rt;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv1();
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (pc !== RV || active !== 1'b1 || in_delay_slot !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: pc=%h act=%b ids=%b, want %h 1 0",
               pc, active, in_delay_slot, RV);
    end
    for (int i = 1; i <= 3; i++) begin
      adv1();
      n_cmp++;
      if (pc !== RV + 4 * i || active !== 1'b1 || in_delay_slot !== 1'b0) begin
        n_err++;
        $display("FAIL seq_step%0d: pc=%h ids=%b act=%b, want %h 0 1",
                 i, pc, in_delay_slot, active, RV + 4 * i);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    cyc(0, 1, 1, 32'h4, 0, 0, 0, 0);
    n_cmp++;
    if (pc !== 32'hBFC00004 || in_delay_slot !== 1'b1) begin
      n_err++;
      $display("FAIL branch_slot: pc=%h ids=%b, want bfc00004 1",
               pc, in_delay_slot);
    end
    adv1();
    n_cmp++;
    if (pc !== 32'hBFC00014 || in_delay_slot !== 1'b0) begin
      n_err++;
      $display("FAIL branch_tgt: pc=%h ids=%b, want bfc00014 0",
               pc, in_delay_slot);
    end
  endtask

  task automatic test_stall_delay();
    do_reset();
    cyc(0, 1, 1, 32'h4, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 32'h40, 1, 26'h3, 1, 32'h1234);
      n_cmp++;
      if (pc !== 32'hBFC00004 || in_delay_slot !== 1'b1) begin
        n_err++;
        $display("FAIL stall%0d: pc=%h ids=%b, want bfc00004 1",
                 i, pc, in_delay_slot);
      end
    end
    adv1();
    n_cmp++;
    if (pc !== 32'hBFC00014 || in_delay_slot !== 1'b0) begin
      n_err++;
      $display("FAIL stall_tgt: pc=%h ids=%b, want bfc00014 0",
               pc, in_delay_slot);
    end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (4) adv1();
    cyc(0, 1, 0, 0, 0, 0, 1, 32'h0);
    n_cmp++;
    if (pc !== 32'hBFC00014 || in_delay_slot !== 1'b1 || active !== 1'b1) begin
      n_err++;
      $display("FAIL halt_slot: pc=%h ids=%b act=%b, want bfc00014 1 1",
               pc, in_delay_slot, active);
    end
    adv1();
    n_cmp++;
    if (pc !== 32'h0 || active !== 1'b0) begin
      n_err++;
      $display("FAIL halt_enter: pc=%h act=%b, want 0 0", pc, active);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 32'h10, 1, 26'h55, 0, 0);
      n_cmp++;
      if (pc !== 32'h0 || active !== 1'b0 || in_delay_slot !== 1'b0) begin
        n_err++;
        $display("FAIL halt_hold%0d: pc=%h act=%b ids=%b, want 0 0 0",
                 i, pc, active, in_delay_slot);
      end
    end
  endtask

  task automatic test_jump_priority();
    do_reset();
    repeat (8) adv1();
    n_cmp++;
    if (pc !== 32'hBFC00020 || link_addr !== 32'hBFC00028) begin
      n_err++;
      $display("FAIL jump_link: pc=%h link=%h, want bfc00020 bfc00028",
               pc, link_addr);
    end
    cyc(0, 1, 1, 32'h8, 1, 26'h0000100, 0, 0);
    adv1();
    n_cmp++;
    if (pc !== 32'hB0000400 || in_delay_slot !== 1'b0) begin
      n_err++;
      $display("FAIL jump_prio: pc=%h ids=%b, want b0000400 0",
               pc, in_delay_slot);
    end
  endtask

  task automatic test_reset_in_delay();
    do_reset();
    cyc(0, 1, 1, 32'h100, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (pc !== RV || in_delay_slot !== 1'b0 || active !== 1'b1) begin
      n_err++;
      $display("FAIL rst_delay: pc=%h ids=%b act=%b, want %h 0 1",
               pc, in_delay_slot, active, RV);
    end
    adv1();
    n_cmp++;
    if (pc !== RV + 4 || in_delay_slot !== 1'b0) begin
      n_err++;
      $display("FAIL rst_drop: pc=%h ids=%b, want %h 0",
               pc, in_delay_slot, RV + 4);
    end
  endtask

  task automatic test_random();
    logic [15:0] imm;
    logic [31:0] rt;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      imm = 16'($urandom);
      rt  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      cyc($urandom_range(0, 49) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 4) == 0,
          {{16{imm[15]}}, imm},
          $urandom_range(0, 9) == 0,
          26'($urandom),
          $urandom_range(0, 9) == 0,
          rt);
      n_cmp++;
      if (pc !== m_pc || link_addr !== m_pc + 8 ||
          in_delay_slot !== (m_q.size() != 0) || active !== !m_halt) begin
        n_err++;
        if (bad < 10)
          $display("FAIL rand%0d: pc=%h ids=%b act=%b, want %h %b %b",
                   i, pc, in_delay_slot, active,
                   m_pc, m_q.size() != 0, !m_halt);
        bad++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; advance = 1'b0; condition_met = 1'b0;
    branch_offset = '0; jump = 1'b0; jump_index = '0;
    jump_reg = 1'b0; reg_target = '0;
    m_pc = RV; m_halt = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_branch();
    test_stall_delay();
    test_halt();
    test_jump_priority();
    test_reset_in_delay();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer side of the branch-decision path: takes the taken/not-taken decision, the jump controls and the operands, and owns the program counter.
- Implements the MIPS branch delay slot: a taken redirect is held pending for exactly one retired instruction, then applied.
- Detects the halt condition (redirect to address 0x00000000) and drops `active`.
- Sits between the control/branch-condition logic and the instruction-fetch address mux.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, redirect target that halts the CPU once its delay slot retires.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- advance  input  1  current instruction retires this cycle; the PC may move only when high
- condition_met  input  1  conditional branch taken (already qualified by the branch control)
- branch_offset  input  32  sign-extended 16-bit immediate, in words
- jump  input  1  J/JAL: absolute jump
- jump_index  input  26  instruction[25:0]
- jump_reg  input  1  JR/JALR: register jump
- reg_target  input  32  rs value for JR/JALR
- pc  output  32  address of the current instruction
- link_addr  output  32  pc+8, the return address for JAL/JALR/BGEZAL/BLTZAL
- in_delay_slot  output  1  current instruction is a delay-slot instruction
- active  output  1  low once halted

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_VECTOR, state=SEQ, pending_target=0, in_delay_slot=0, active=1.
  - Reset wins over every other input and clears any pending redirect mid-operation.
- Combinational outputs:
  - link_addr = pc+8.
  - in_delay_slot = (state==DELAY).
  - active = (state!=HALTED).
- Arithmetic: all additions are mod 2^32; wrap-around is silently allowed.
  - pc4 = pc+4.
  - branch target = pc4 + (branch_offset<<2), low 2 bits always 0.
  - jump target = {pc4[31:28], jump_index, 2'b00}.
  - reg target = reg_target as given; no alignment check.
- Redirect priority when several controls are high in one cycle: jump_reg > jump > condition_met.
- States:
  - SEQ, advance=0: hold everything (stall).
  - SEQ, advance=1 with a redirect: pc<=pc4, pending_target<=selected target, ->DELAY.
  - SEQ, advance=1 without a redirect: pc<=pc4, stay SEQ.
  - DELAY, advance=0: hold; pending_target stays stable across any stall length.
  - DELAY, advance=1, pending_target==HALT_ADDR: pc<=pending_target, ->HALTED.
  - DELAY, advance=1, otherwise: pc<=pending_target, ->SEQ.
  - DELAY: redirect inputs are ignored (branch in a delay slot is architecturally undefined; the decision here is to ignore it).
  - HALTED: pc frozen at HALT_ADDR; all inputs ignored except reset.
- Latency:
  - The redirect becomes visible on pc exactly one advance after the advance that retired the branch/jump.
  - The instruction at pc4 always executes, regardless of stall cycles in between.
- A redirect into HALT_ADDR still executes its delay slot before halting.
- A sequential step that wraps to 0 does not halt; only a redirect target does.

Decomposition:
- Shared package mips_pkg holds:
  - typedef state_t {SEQ, DELAY, HALTED};
  - constants RESET_VECTOR_C and HALT_ADDR_C, used as the parameter defaults;
  - typedef addr_t (logic[31:0]).
- One natural sub-module, pc_target_calc: combinational target selection and priority mux, producing target and redirect.
- The sequential state machine stays in pc_sequencer.

Test Plan:
- Reset, then 3 advances -> pc = BFC00000, BFC00004, BFC00008, BFC0000C; active=1; in_delay_slot=0 throughout.
- At pc=BFC00000: condition_met=1, offset=32'h00000004, advance. Then advance twice more -> pc sequence BFC00004 (in_delay_slot=1), then BFC00014 (in_delay_slot=0).
- Taken branch, then advance=0 for 5 cycles in DELAY, then advance -> pc holds BFC00004 during the stall, then becomes target; pending_target unchanged.
- At pc=BFC00010: jump_reg=1, reg_target=0, advance. Then advance -> pc=BFC00014 with in_delay_slot=1, then pc=0 and active=0. Further advances with jump=1 -> pc stays 0.
- At pc=BFC00020: jump=1, jump_index=26'h0000100, condition_met=1, advance -> after the delay slot pc=B0000400 (jump beats branch); link_addr at the jump instruction = BFC00028.
- Assert reset while in DELAY with a pending target -> next cycle pc=BFC00000, state SEQ, and the pending redirect is never applied.
